sdram_cpu_port: RTL

// - Client-side initiator for the byte-wide SDRAM controller rd/we/ready handshake.
// - Converts single-cycle CPU read/write strobes into the controller's rising-edge requests.
// - Waits for ready, returns read data, and adds a one-deep pending slot plus a timeout watchdog.
// - Sits between the Z80 memory decoder and the SDRAM controller, both on clk (~100MHz).

---
 rtl/sdram_cpu_port_if.sv | 28 ++
 rtl/sdram_cpu_port.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sdram_cpu_port_if.sv
// CPU strobe bus and SDRAM controller handshake for sdram_cpu_port.
// master: the port block itself; slave: the CPU decoder plus controller side.
interface sdram_cpu_port_if;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        timeout;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic        sd_rd;
    logic        sd_we;
    logic [7:0]  sd_dout;
    logic        sd_ready;

    modport master (
        input  cpu_addr, cpu_din, cpu_rd, cpu_wr, sd_dout, sd_ready,
        output cpu_dout, cpu_ack, cpu_busy, timeout, sd_addr, sd_din, sd_rd, sd_we
    );

    modport slave (
        output cpu_addr, cpu_din, cpu_rd, cpu_wr, sd_dout, sd_ready,
        input  cpu_dout, cpu_ack, cpu_busy, timeout, sd_addr, sd_din, sd_rd, sd_we
    );
endinterface

// File: rtl/sdram_cpu_port.sv
// CPU-side initiator for the SDRAM controller rd/we/ready handshake, with a one-deep
// pending slot and a watchdog. Define SDRAM_CPU_PORT_WPOST_EN to enable posted writes.
module sdram_cpu_port #(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 63
) (
    input  logic             clk,
    input  logic             init,
    sdram_cpu_port_if.master bus
);
    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

`ifdef SDRAM_CPU_PORT_WPOST_EN
    localparam bit WPOST = 1'b1;
`else
    localparam bit WPOST = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t        state_q;
    logic          slot_full_q;
    logic          slot_we_q;
    logic [24:0]   slot_addr_q;
    logic [7:0]    slot_din_q;
    logic          req_we_q;
    logic [GW-1:0] guard_q;
    logic [5:0]    wdog_q;
    logic [5:0]    wdog_d;
    logic [24:0]   sd_addr_q;
    logic [7:0]    sd_din_q;
    logic          sd_rd_q;
    logic          sd_we_q;
    logic [7:0]    cpu_dout_q;
    logic          cpu_ack_q;
    logic          timeout_q;
    logic          accept;
    logic          wait_done;
    logic          posted_req;

    always_comb begin
        accept     = !slot_full_q && (bus.cpu_rd || bus.cpu_wr);
        wdog_d     = (wdog_q == 6'h3F) ? wdog_q : wdog_q + 6'd1;
        wait_done  = bus.sd_ready || (wdog_d == 6'(TIMEOUT));
        posted_req = WPOST && req_we_q;
    end

    // NOTE: all state below is assigned with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= S_IDLE;
            slot_full_q <= 1'b0;
            slot_we_q   <= 1'b0;
            slot_addr_q <= '0;
            slot_din_q  <= '0;
            req_we_q    <= 1'b0;
            guard_q     <= '0;
            wdog_q      <= '0;
            sd_addr_q   <= '0;
            sd_din_q    <= '0;
            sd_rd_q     <= 1'b0;
            sd_we_q     <= 1'b0;
            cpu_dout_q  <= 8'hFF;
            cpu_ack_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;

            // A simultaneous rd+wr is recorded as a write.
            if (accept) begin
                slot_full_q <= 1'b1;
                slot_we_q   <= bus.cpu_wr;
                slot_addr_q <= bus.cpu_addr;
                slot_din_q  <= bus.cpu_din;
                if (WPOST && bus.cpu_wr) cpu_ack_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (slot_full_q && bus.sd_ready) begin
                        sd_addr_q <= slot_addr_q;
                        sd_din_q  <= slot_din_q;
                        sd_we_q   <= slot_we_q;
                        sd_rd_q   <= !slot_we_q;
                        req_we_q  <= slot_we_q;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    slot_full_q <= 1'b0;
                    guard_q     <= '0;
                    wdog_q      <= '0;
                    state_q     <= S_GUARD;
                end
                S_GUARD: begin
                    // sd_ready may still reflect the previous access until the guard expires.
                    if (guard_q == GW'(GUARD_CYCLES - 1)) state_q <= S_WAIT;
                    else guard_q <= guard_q + 1'b1;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        sd_rd_q <= 1'b0;
                        sd_we_q <= 1'b0;
                        state_q <= S_RELEASE;
                        if (!posted_req) cpu_ack_q <= 1'b1;
                        if (bus.sd_ready) begin
                            if (!req_we_q) cpu_dout_q <= bus.sd_dout;
                        end else begin
                            timeout_q <= 1'b1;
                            if (!posted_req) cpu_dout_q <= 8'hFF;
                        end
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                S_RELEASE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.sd_addr  = sd_addr_q;
    assign bus.sd_din   = sd_din_q;
    assign bus.sd_rd    = sd_rd_q;
    assign bus.sd_we    = sd_we_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.cpu_busy = slot_full_q;
    assign bus.timeout  = timeout_q;
endmodule
